// File: rtl/iir_sos_cascade_engine_if.sv
// Sample, coefficient and frame-status bundle for the SOS cascade engine.
// The source/controller side uses master; the engine uses slave.
interface iir_sos_cascade_engine_if #(
    parameter int DW = 24,
    parameter int CW = 24,
    parameter int AW = 11
);
    logic                 start;
    logic signed [DW-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 coef_we;
    logic [3:0]           coef_sec;
    logic [2:0]           coef_sel;
    logic signed [CW-1:0] coef_wdata;
    logic                 coef_err;
    logic signed [DW-1:0] out_data;
    logic                 out_valid;
    logic [AW-1:0]        addr;
    logic                 filter_done;
    logic                 stable_out;

    modport master (
        output start, in_data, in_valid,
        output coef_we, coef_sec, coef_sel, coef_wdata,
        input  in_ready, coef_err, out_data, out_valid,
        input  addr, filter_done, stable_out
    );

    modport slave (
        input  start, in_data, in_valid,
        input  coef_we, coef_sec, coef_sel, coef_wdata,
        output in_ready, coef_err, out_data, out_valid,
        output addr, filter_done, stable_out
    );
endinterface

// File: rtl/iir_sos_cascade_engine.sv
// Time-multiplexed DF-I biquad cascade: NSEC sections per sample, one per cycle,
// with runtime coefficient bank, frame addressing and a settle detector.
module iir_sos_cascade_engine #(
    parameter int DW         = 24,
    parameter int CW         = 24,
    parameter int FRAC       = 22,
    parameter int NSEC       = 4,
    parameter int FRAME_LEN  = 2048,
    parameter int AW         = 11,
    parameter int STABLE_TOL = 16,
    parameter int STABLE_CNT = 32
) (
    input logic clk,
    input logic rst,
    iir_sos_cascade_engine_if.slave bus
);
    localparam int ACCW = DW + CW + 3;
    localparam int YW   = ACCW - FRAC;
    localparam int SW   = (NSEC > 1) ? $clog2(NSEC) : 1;
    localparam int SCW  = $clog2(STABLE_CNT + 1);

    localparam logic signed [ACCW-1:0] HALF = ACCW'(1) << (FRAC - 1);
    localparam logic signed [CW-1:0]   ONE  = CW'(1) << FRAC;
    localparam logic signed [YW-1:0]   YMAX = YW'({1'b0, {(DW-1){1'b1}}});
    localparam logic signed [YW-1:0]   YMIN = ~YMAX;

    typedef enum logic [2:0] {IDLE, RUN, CALC, OUT, DONE} state_t;

    state_t               state_q;
    logic [SW-1:0]        sec_q;
    logic [AW-1:0]        cnt_q;
    logic [AW-1:0]        addr_q;
    logic signed [DW-1:0] cur_q;
    logic signed [DW-1:0] out_data_q;
    logic signed [DW-1:0] prev_q;
    logic                 out_valid_q;
    logic                 err_q;
    logic                 stable_q;
    logic [SCW-1:0]       stab_q;
    logic [SCW-1:0]       stab_d;

    logic signed [CW-1:0] b0_q [NSEC];
    logic signed [CW-1:0] b1_q [NSEC];
    logic signed [CW-1:0] b2_q [NSEC];
    logic signed [CW-1:0] a1_q [NSEC];
    logic signed [CW-1:0] a2_q [NSEC];
    logic signed [DW-1:0] x1_q [NSEC];
    logic signed [DW-1:0] x2_q [NSEC];
    logic signed [DW-1:0] y1_q [NSEC];
    logic signed [DW-1:0] y2_q [NSEC];

    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] rnd;
    logic signed [YW-1:0]   yfull;
    logic signed [DW-1:0]   y_sat;
    logic signed [DW:0]     diff;
    logic [DW:0]            mag;
    logic                   settled;
    logic                   coef_ok;
    logic [SW-1:0]          wsec;

    function automatic logic signed [ACCW-1:0] mul(
        input logic signed [CW-1:0] c,
        input logic signed [DW-1:0] d
    );
        return ACCW'(c) * ACCW'(d);
    endfunction

    always_comb begin
        acc = mul(b0_q[sec_q], cur_q)
            + mul(b1_q[sec_q], x1_q[sec_q])
            + mul(b2_q[sec_q], x2_q[sec_q])
            - mul(a1_q[sec_q], y1_q[sec_q])
            - mul(a2_q[sec_q], y2_q[sec_q]);
        rnd   = acc + HALF;
        yfull = rnd[ACCW-1:FRAC];
        if (yfull > YMAX) begin
            y_sat = {1'b0, {(DW-1){1'b1}}};
        end else if (yfull < YMIN) begin
            y_sat = {1'b1, {(DW-1){1'b0}}};
        end else begin
            y_sat = yfull[DW-1:0];
        end
    end

    // Settle detector works on the value about to be presented in OUT.
    always_comb begin
        diff    = {cur_q[DW-1], cur_q} - {prev_q[DW-1], prev_q};
        mag     = diff[DW] ? -diff : diff;
        settled = (mag <= (DW+1)'(STABLE_TOL));
        stab_d  = '0;
        if (settled) begin
            if (stab_q == SCW'(STABLE_CNT)) begin
                stab_d = stab_q;
            end else begin
                stab_d = stab_q + 1'b1;
            end
        end
    end

    always_comb begin
        coef_ok = (state_q == IDLE || state_q == DONE)
                && ({1'b0, bus.coef_sec} < 5'(NSEC))
                && (bus.coef_sel <= 3'd4);
        wsec    = bus.coef_sec[SW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sec_q       <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            cur_q       <= '0;
            out_data_q  <= '0;
            prev_q      <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            stable_q    <= 1'b0;
            stab_q      <= '0;
            for (int k = 0; k < NSEC; k++) begin
                b0_q[k] <= ONE;
                b1_q[k] <= '0;
                b2_q[k] <= '0;
                a1_q[k] <= '0;
                a2_q[k] <= '0;
                x1_q[k] <= '0;
                x2_q[k] <= '0;
                y1_q[k] <= '0;
                y2_q[k] <= '0;
            end
        end else begin
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;

            if (bus.coef_we) begin
                if (coef_ok) begin
                    case (bus.coef_sel)
                        3'd0:    b0_q[wsec] <= bus.coef_wdata;
                        3'd1:    b1_q[wsec] <= bus.coef_wdata;
                        3'd2:    b2_q[wsec] <= bus.coef_wdata;
                        3'd3:    a1_q[wsec] <= bus.coef_wdata;
                        3'd4:    a2_q[wsec] <= bus.coef_wdata;
                        default: ;
                    endcase
                end else begin
                    err_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q  <= RUN;
                        cnt_q    <= '0;
                        stab_q   <= '0;
                        stable_q <= 1'b0;
                        prev_q   <= '0;
                        for (int k = 0; k < NSEC; k++) begin
                            x1_q[k] <= '0;
                            x2_q[k] <= '0;
                            y1_q[k] <= '0;
                            y2_q[k] <= '0;
                        end
                    end
                end
                RUN: begin
                    if (bus.in_valid) begin
                        cur_q   <= bus.in_data;
                        sec_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    x1_q[sec_q] <= cur_q;
                    x2_q[sec_q] <= x1_q[sec_q];
                    y1_q[sec_q] <= y_sat;
                    y2_q[sec_q] <= y1_q[sec_q];
                    cur_q       <= y_sat;
                    if (sec_q == SW'(NSEC - 1)) begin
                        state_q <= OUT;
                    end else begin
                        sec_q <= sec_q + 1'b1;
                    end
                end
                OUT: begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= cur_q;
                    addr_q      <= cnt_q;
                    cnt_q       <= cnt_q + 1'b1;
                    prev_q      <= cur_q;
                    stab_q      <= stab_d;
                    stable_q    <= (stab_d >= SCW'(STABLE_CNT));
                    if (cnt_q == AW'(FRAME_LEN - 1)) begin
                        state_q <= DONE;
                    end else begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (state_q == RUN);
    assign bus.filter_done = (state_q == DONE);
    assign bus.coef_err    = err_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.addr        = addr_q;
    assign bus.stable_out  = stable_q;
endmodule

// File: tb/tb_iir_sos_cascade_engine.sv
// Scoreboard bench for the SOS cascade engine: directed samples push expected
// outputs; a negedge monitor pops and compares on every out_valid.
module tb_iir_sos_cascade_engine;
    localparam int DW = 24;
    localparam int CW = 24;
    localparam int AW = 3;
    localparam int FL = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    iir_sos_cascade_engine_if #(.DW(DW), .CW(CW), .AW(AW)) bus ();

    iir_sos_cascade_engine #(
        .DW(DW), .CW(CW), .FRAC(22), .NSEC(4), .FRAME_LEN(FL),
        .AW(AW), .STABLE_TOL(16), .STABLE_CNT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic signed [DW-1:0] d;
        logic [AW-1:0]        a;
        logic                 s;
        int                   cyc;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("stray out_valid", 1, 0);
            end else begin
                me = q.pop_front();
                chk("out_data", bus.out_data, me.d);
                chk("addr", bus.addr, me.a);
                chk("stable_out", bus.stable_out, me.s);
                chk("latency", cyc, me.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic startf();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wcoef(input int sec, input int sel,
                         input logic signed [CW-1:0] v,
                         input bit exp_err, input bit with_start);
        bus.coef_we    = 1'b1;
        bus.coef_sec   = sec[3:0];
        bus.coef_sel   = sel[2:0];
        bus.coef_wdata = v;
        bus.start      = with_start;
        tick();
        bus.coef_we = 1'b0;
        bus.start   = 1'b0;
        chk("coef_err", bus.coef_err, exp_err);
    endtask

    task automatic send(input logic signed [DW-1:0] x,
                        input logic signed [DW-1:0] ed,
                        input int ea, input bit es, input bit push);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            chk("in_ready timeout", 0, 1);
            return;
        end
        bus.in_data  = x;
        bus.in_valid = 1'b1;
        if (push) q.push_back('{ed, ea[AW-1:0], es, cyc + 6});
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        if (q.size() > 0) begin
            chk("drain timeout", q.size(), 0);
            q.delete();
        end
        tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " out_valid"}, bus.out_valid, 0);
        chk({tag, " out_data"}, bus.out_data, 0);
        chk({tag, " addr"}, bus.addr, 0);
        chk({tag, " filter_done"}, bus.filter_done, 0);
        chk({tag, " stable_out"}, bus.stable_out, 0);
        chk({tag, " in_ready"}, bus.in_ready, 0);
        chk({tag, " coef_err"}, bus.coef_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start      = 1'b0;
        bus.in_data    = '0;
        bus.in_valid   = 1'b0;
        bus.coef_we    = 1'b0;
        bus.coef_sec   = '0;
        bus.coef_sel   = '0;
        bus.coef_wdata = '0;
        do_reset();
        chk_zero("reset");

        // pass-through defaults, latency and busy window
        startf();
        chk("in_ready in RUN", bus.in_ready, 1);
        send(1000, 1000, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            chk("in_ready busy", bus.in_ready, 0);
            tick();
        end
        chk("in_ready back", bus.in_ready, 1);
        drain();

        // coefficient writes: illegal index/sel, legal b0, rejected in RUN
        do_reset();
        wcoef(0, 5, 24'sd0, 1, 0);
        wcoef(4, 0, 24'sd0, 1, 0);
        wcoef(0, 0, 24'sd2097152, 0, 0);
        startf();
        send(4096, 2048, 0, 0, 1);
        drain();
        wcoef(1, 3, 24'sd12345, 1, 0);
        send(4096, 2048, 1, 0, 1);
        drain();

        // recursion with round-half-up
        do_reset();
        wcoef(0, 3, -24'sd2097152, 0, 0);
        startf();
        send(1000, 1000, 0, 0, 1);
        send(0, 500, 1, 0, 1);
        send(0, 250, 2, 0, 1);
        send(0, 125, 3, 0, 1);
        send(0, 63, 4, 0, 1);
        drain();

        // saturation in every section
        do_reset();
        for (int s = 0; s < 4; s++) wcoef(s, 0, 24'sd8388607, 0, 0);
        startf();
        send(24'sd8388607, 24'sd8388607, 0, 0, 1);
        send(-24'sd8388608, -24'sd8388608, 1, 0, 1);
        send(0, 0, 2, 0, 1);
        drain();

        // full frame, settle detector, ignored start, restart with write
        do_reset();
        startf();
        for (int i = 0; i < FL; i++) begin
            send(500, 500, i, (i >= 4), 1);
            if (i == 2) startf();
        end
        drain();
        chk("filter_done at end", bus.filter_done, 1);
        chk("in_ready at end", bus.in_ready, 0);
        wcoef(0, 0, 24'sd2097152, 0, 1);
        chk("filter_done after start", bus.filter_done, 0);
        send(1000, 500, 0, 0, 1);
        drain();

        // reset mid-CALC: abandoned sample, defaults restored
        send(1000, 0, 1, 0, 0);
        tick();
        rst = 1'b1;
        tick();
        chk_zero("mid-reset");
        rst = 1'b0;
        repeat (10) tick();
        startf();
        send(1000, 1000, 0, 0, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
